// File: rtl/apb_regbank.sv
// apb_regbank: parametrised APB3 completer with a register file.
// Writable registers occupy the low indices and read-only status words
// (fed from ro_in) occupy the top RO_REGS indices. Every access phase
// is stretched by WAIT_STATES cycles. Misaligned hits complete with
// PSLVERR, and each committed write raises a one-cycle pulse for its register.
module apb_regbank #(
  parameter logic [31:0] START_ADDRESS = 32'h8c000000,
  parameter int          REG_COUNT     = 112,
  parameter int          RO_REGS       = 4,
  parameter int          DATA_WIDTH    = 32,
  parameter int          WAIT_STATES   = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        PSEL,
  input  logic                                        PENABLE,
  input  logic                                        PWRITE,
  input  logic [31:0]                                 PADDR,
  input  logic [DATA_WIDTH-1:0]                       PWDATA,
  output logic [DATA_WIDTH-1:0]                       PRDATA,
  output logic                                        PREADY,
  output logic                                        PSLVERR,
  output logic [(REG_COUNT-RO_REGS)*DATA_WIDTH-1:0]   regs_out,
  output logic [REG_COUNT-RO_REGS-1:0]                wr_pulse,
  input  logic [RO_REGS*DATA_WIDTH-1:0]               ro_in
);

  localparam int          NW          = REG_COUNT - RO_REGS;
  localparam int          IDX_W       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [32:0] END_ADDRESS = {1'b0, START_ADDRESS} + 33'(4 * REG_COUNT);
  localparam logic [3:0]  WS          = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_hit;
  logic                  w_mis;
  logic                  w_setup;
  logic                  w_access;
  logic                  w_commit;
  logic [31:0]           w_offset;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_unused;

  // Address decode. The compare is done in 33 bits so that a window that
  // ends exactly at the top of the address map cannot wrap around.
  assign w_hit    = ({1'b0, PADDR} >= {1'b0, START_ADDRESS}) && ({1'b0, PADDR} < END_ADDRESS);
  assign w_offset = PADDR - START_ADDRESS;
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_mis    = (PADDR[1:0] != 2'b00);
  assign w_unused = ^{w_offset[31:IDX_W+2], w_offset[1:0]};

  assign w_setup  = PSEL & ~PENABLE & w_hit;
  assign w_access = PSEL & PENABLE & w_hit;

  // Bus responses are combinational from the registered state, so a
  // non-hit address never sees PREADY, PSLVERR or PRDATA.
  assign PREADY   = w_access & (r_state == S_DONE);
  assign PSLVERR  = PREADY & w_mis;
  assign w_commit = PREADY & PWRITE & ~w_mis & (w_idx < IDX_W'(NW));
  assign PRDATA   = (PREADY & ~PWRITE & ~w_mis) ? w_rd_mux : '0;

  // Read mux: writable registers first, then the read-only status words.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NW; i++) begin
      if (w_idx == IDX_W'(i)) w_rd_mux = regs_out[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < RO_REGS; j++) begin
      if (w_idx == IDX_W'(NW + j)) w_rd_mux = ro_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Transfer FSM next-state: a setup phase loads the wait counter, WAIT
  // counts down to DONE, and dropping PSEL aborts from any state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!PSEL) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            w_cnt_next   = WS;
            w_state_next = (WS != 4'd0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_next = S_DONE;
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // One storage word and one write strobe per writable register.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_reg
      logic                  w_sel;
      logic [DATA_WIDTH-1:0] r_reg;
      logic                  r_pulse;

      assign w_sel = w_commit & (w_idx == IDX_W'(gi));

      // Capture PWDATA on commit and pulse for the following cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_reg   <= '0;
          r_pulse <= 1'b0;
        end else begin
          r_pulse <= w_sel;
          if (w_sel) r_reg <= PWDATA;
        end
      end

      assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_reg;
      assign wr_pulse[gi]                          = r_pulse;
    end
  endgenerate

endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: two instances (0 and 3 wait states) share one bus;
// PSEL is routed to the instance selected by cur. A behavioural model
// of the register file predicts every response.
module tb_apb_regbank;

  localparam logic [31:0] START = 32'h8c000000;
  localparam int          RC    = 112;
  localparam int          NW    = 108;
  localparam int          NT    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                psel, penable, pwrite;
  logic [31:0]         paddr, pwdata;
  int                  cur;
  logic                psel0, psel1;
  logic [31:0]         prdata0, prdata1, prdata_m;
  logic                pready0, pready1, pready_m;
  logic                pslverr0, pslverr1, pslverr_m;
  logic [NW*32-1:0]    regs_out0, regs_out1;
  logic [NW-1:0]       wr_pulse0, wr_pulse1, wr_pulse_m;
  logic [127:0]        ro_in;

  logic [31:0]         model [2][NW];
  int                  total = 0;
  int                  bad   = 0;
  logic [31:0]         t_rd;
  bit                  t_rdy, t_err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_rdy;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [NT];

  always #5 clk = ~clk;

  assign psel0      = psel & (cur == 0);
  assign psel1      = psel & (cur == 1);
  assign prdata_m   = (cur == 1) ? prdata1   : prdata0;
  assign pready_m   = (cur == 1) ? pready1   : pready0;
  assign pslverr_m  = (cur == 1) ? pslverr1  : pslverr0;
  assign wr_pulse_m = (cur == 1) ? wr_pulse1 : wr_pulse0;

  apb_regbank #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .regs_out(regs_out0), .wr_pulse(wr_pulse0), .ro_in(ro_in)
  );

  apb_regbank #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .regs_out(regs_out1), .wr_pulse(wr_pulse1), .ro_in(ro_in)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm, input int d);
    int first;
    logic [31:0] a, fa, fe;
    first = -1;
    fa = '0;
    fe = '0;
    for (int i = 0; i < NW; i++) begin
      a = (d == 1) ? regs_out1[i*32 +: 32] : regs_out0[i*32 +: 32];
      if (a !== model[d][i] && first < 0) begin
        first = i;
        fa = a;
        fe = model[d][i];
      end
    end
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: dut%0d reg%0d got %h want %h", nm, d, first, fa, fe);
    end
  endtask

  function automatic logic [NW-1:0] onehot(input int idx);
    logic [NW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Reference: window membership, index and read value from plain arithmetic.
  function automatic void model_eval(input int d, input bit wr, input logic [31:0] addr,
                                     output bit hit, output bit mis, output int idx,
                                     output logic [31:0] rd);
    longint a, s;
    a   = {32'd0, addr};
    s   = {32'd0, START};
    hit = (a >= s) && (a < s + 4 * RC);
    mis = (a % 4) != 0;
    idx = hit ? int'((a - s) / 4) : 0;
    rd  = '0;
    if (hit && !wr && !mis) rd = (idx < NW) ? model[d][idx] : ro_in[(idx-NW)*32 +: 32];
  endfunction

  // Full APB transfer; checks side effects against the model, returns bus results.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output bit rdy, output bit err);
    bit hit, mis, commit, noisy;
    int idx, ws, waits;
    logic [31:0] mrd;
    logic [NW-1:0] exp_pulse;
    model_eval(d, wr, addr, hit, mis, idx, mrd);
    ws     = (d == 1) ? 3 : 0;
    commit = hit && wr && !mis && (idx < NW);
    @(posedge clk); #1;
    cur = d; psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1; waits = 0; rdy = 0; err = 0; rd = '0; noisy = 0;
    for (int c = 0; c < ws + 6; c++) begin
      #1;
      if (pready_m) begin
        rdy = 1; rd = prdata_m; err = pslverr_m;
        break;
      end
      if (prdata_m != 0 || pslverr_m || wr_pulse_m != 0) noisy = 1;
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
    #1;
    exp_pulse = '0;
    if (commit) begin
      exp_pulse = onehot(idx);
      model[d][idx] = data;
    end
    chk("pulse_set", wr_pulse_m, exp_pulse);
    chk_regs("regs_after", d);
    if (hit) chk("wait_cycles", waits, ws);
    chk("quiet_before_ready", noisy, 0);
    @(posedge clk); #2;
    chk("pulse_clear", wr_pulse_m, 0);
    $display("xfer dut%0d %s addr=%h data=%h rdy=%0b err=%0b rd=%h waits=%0d",
             d, wr ? "W" : "R", addr, data, rdy, err, rd, waits);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit, mis, wr;
    int idx, k, d;
    logic [31:0] mrd, addr, data;

    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; cur = 0; rst = 1;
    ro_in = {32'hcafef00d, 32'h0badf00d, 32'h00c0ffee, 32'h12345678};
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < NW; i++) model[dd][i] = '0;

    tbl[0]  = '{0, 32'h8c000000, 32'h0,        1, 0, 32'h0};
    tbl[1]  = '{1, 32'h8c000008, 32'hdeadbeef, 1, 0, 32'h0};
    tbl[2]  = '{0, 32'h8c000008, 32'h0,        1, 0, 32'hdeadbeef};
    tbl[3]  = '{0, 32'h8c0001b0, 32'h0,        1, 0, 32'h12345678};
    tbl[4]  = '{1, 32'h8c0001b0, 32'hffffffff, 1, 0, 32'h0};
    tbl[5]  = '{0, 32'h8c0001b0, 32'h0,        1, 0, 32'h12345678};
    tbl[6]  = '{1, 32'h8c000006, 32'h00000055, 1, 1, 32'h0};
    tbl[7]  = '{0, 32'h8c000006, 32'h0,        1, 1, 32'h0};
    tbl[8]  = '{0, 32'h8c000008, 32'h0,        1, 0, 32'hdeadbeef};
    tbl[9]  = '{0, 32'h8c000300, 32'h0,        0, 0, 32'h0};
    tbl[10] = '{1, 32'h8c000300, 32'h12121212, 0, 0, 32'h0};
    tbl[11] = '{0, 32'h8bfffffc, 32'h0,        0, 0, 32'h0};
    tbl[12] = '{0, 32'h8c0001bc, 32'h0,        1, 0, 32'hcafef00d};
    tbl[13] = '{1, 32'h8c0001ac, 32'ha5a5a5a5, 1, 0, 32'h0};
    tbl[14] = '{0, 32'h8c0001ac, 32'h0,        1, 0, 32'ha5a5a5a5};
    tbl[15] = '{0, 32'h8c0001c0, 32'h0,        0, 0, 32'h0};

    // Reset with an access-phase hit on the bus: outputs must stay quiet.
    psel = 1; penable = 1; paddr = START;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pready", pready_m, 0);
    chk("rst_prdata", prdata_m, 0);
    chk("rst_pslverr", pslverr_m, 0);
    chk("rst_pulse0", wr_pulse0, 0);
    chk("rst_pulse3", wr_pulse1, 0);
    chk_regs("rst_regs0", 0);
    chk_regs("rst_regs3", 1);
    psel = 0; penable = 0;
    @(negedge clk) rst = 0;

    // Directed table on the zero-wait-state instance.
    for (int i = 0; i < NT; i++) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, t_rd, t_rdy, t_err);
      chk($sformatf("tbl%0d_rdy", i), t_rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_err", i), t_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_rd", i), t_rd, tbl[i].exp_rd);
    end

    // Three wait states: PREADY only on the 4th access cycle, commit after it.
    @(posedge clk); #1;
    cur = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h8c000004; pwdata = 32'h11112222;
    @(posedge clk); #1;
    penable = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ws3_wait%0d_pready", c), pready_m, 0);
      chk($sformatf("ws3_wait%0d_reg1", c), regs_out1[63:32], model[1][1]);
      @(posedge clk); #1;
    end
    #1;
    chk("ws3_ready_4th", pready_m, 1);
    chk("ws3_reg1_before_edge", regs_out1[63:32], model[1][1]);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    #1;
    model[1][1] = 32'h11112222;
    chk("ws3_reg1_committed", regs_out1[63:32], 32'h11112222);
    chk("ws3_pulse", wr_pulse_m, onehot(1));
    @(posedge clk); #2;
    chk("ws3_pulse_clear", wr_pulse_m, 0);
    $display("xfer dut1 W addr=8c000004 data=11112222 wait-state sequence");

    // Abort: PSEL dropped after one wait cycle.
    @(posedge clk); #1;
    cur = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h8c00000c; pwdata = 32'h33334444;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_pulse", wr_pulse_m, 0);
    chk_regs("abort_regs", 1);
    $display("xfer dut1 W addr=8c00000c data=33334444 aborted");
    xfer(1, 0, 32'h8c00000c, 32'h0, t_rd, t_rdy, t_err);
    chk("abort_readback_rdy", t_rdy, 1);
    chk("abort_readback_rd", t_rd, model[1][3]);

    // Reset pulsed in the middle of a wait-stated write.
    @(posedge clk); #1;
    cur = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h8c000004; pwdata = 32'h99999999;
    @(posedge clk); #1;
    penable = 1;
    #3;
    rst = 1;
    #1;
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < NW; i++) model[dd][i] = '0;
    chk("midrst_pready", pready_m, 0);
    chk_regs("midrst_regs3", 1);
    chk_regs("midrst_regs0", 0);
    @(posedge clk); #1;
    chk("midrst_pready_held", pready_m, 0);
    psel = 0; penable = 0;
    @(negedge clk) rst = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("midrst_pulse", wr_pulse_m, 0);
    chk_regs("midrst_after", 1);
    $display("xfer dut1 W addr=8c000004 data=99999999 reset mid-transfer");
    xfer(1, 0, 32'h8c000004, 32'h0, t_rd, t_rdy, t_err);
    chk("midrst_read_rd", t_rd, 0);

    // Back-to-back write then read on the zero-wait-state instance.
    @(posedge clk); #1;
    cur = 0; psel = 1; penable = 0; pwrite = 1; paddr = 32'h8c000010; pwdata = 32'h0f0f0f0f;
    @(posedge clk); #1;
    penable = 1;
    #1;
    chk("b2b_wr_ready", pready_m, 1);
    @(posedge clk); #1;
    penable = 0; pwrite = 0;
    #1;
    model[0][4] = 32'h0f0f0f0f;
    chk("b2b_pulse", wr_pulse_m, onehot(4));
    chk_regs("b2b_regs", 0);
    @(posedge clk); #1;
    penable = 1;
    #1;
    chk("b2b_rd_ready", pready_m, 1);
    chk("b2b_rd_data", prdata_m, 32'h0f0f0f0f);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(posedge clk); #2;
    chk("b2b_pulse_clear", wr_pulse_m, 0);
    $display("xfer dut0 W+R addr=8c000010 data=0f0f0f0f back-to-back");

    // Randomised traffic against the model on both instances.
    for (int n = 0; n < 80; n++) begin
      d    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      k    = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: addr = START + 32'(4 * $urandom_range(0, 7));
        4:          addr = START + 32'(4 * $urandom_range(0, NW - 1));
        5:          addr = START + 32'(4 * $urandom_range(NW, RC - 1));
        6:          addr = START + 32'(4 * $urandom_range(0, RC - 1)) + 32'($urandom_range(1, 3));
        7:          addr = START - 32'(4 * $urandom_range(1, 64));
        8:          addr = START + 32'(4 * RC) + 32'(4 * $urandom_range(0, 64));
        default:    addr = $urandom;
      endcase
      model_eval(d, wr, addr, hit, mis, idx, mrd);
      xfer(d, wr, addr, data, t_rd, t_rdy, t_err);
      chk("rand_rdy", t_rdy, hit);
      chk("rand_err", t_err, hit & mis);
      chk("rand_rd", t_rd, mrd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_regbank.md
Name: apb_regbank

Overview:
- Parametrised APB3 completer with a register file, for the audioport APB bus section; successor to the fixed-range, zero-wait-state APB configuration.
- Generalises four things: base address, register count, data width, and number of wait states.
- Adds read-only status registers, per-register write pulses, and PSLVERR on misaligned access.
- Sits between the APB interconnect and the core's control/status logic.

Parameters:
- START_ADDRESS, 32'h8c000000, byte address of register 0.
- REG_COUNT, 112, total registers; register i lives at START_ADDRESS+4*i (default last address 32'h8c0001bc).
- RO_REGS, 4, number of read-only registers; these are the highest indices REG_COUNT-RO_REGS..REG_COUNT-1. Range 0..REG_COUNT-1.
- DATA_WIDTH, 32, register/PWDATA/PRDATA width; must be 32 or less.
- WAIT_STATES, 0, wait cycles inserted in every access phase; range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  APB byte address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- regs_out  out  (REG_COUNT-RO_REGS)*DATA_WIDTH  writable register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  REG_COUNT-RO_REGS  one-cycle pulse per writable register, asserted after that register is written
- ro_in  in  RO_REGS*DATA_WIDTH  values returned for the read-only registers

Behaviour:
- Reset: asynchronous and active-high.
  - All writable registers = 0, wr_pulse = 0, FSM = IDLE, wait counter = 0.
  - PRDATA/PREADY/PSLVERR read 0 while rst = 1.
- Address decode:
  - hit = PADDR in [START_ADDRESS, START_ADDRESS+4*REG_COUNT-1].
  - idx = (PADDR-START_ADDRESS)>>2.
  - misaligned = PADDR[1:0] != 0.
  - Non-hit: block never drives PREADY, PSLVERR or PRDATA (all 0) and has no side effects.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: PSEL & !PENABLE & hit (setup phase) loads cnt = WAIT_STATES. Next state is WAIT if WAIT_STATES > 0, else DONE.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, next state is DONE.
  - DONE: unconditionally returns to IDLE next cycle.
  - PSEL = 0 in any state returns the FSM to IDLE with no write (abort).
- Output drive during the access phase (PSEL & PENABLE & hit):
  - PREADY = (state == DONE) & PSEL & PENABLE & hit; PREADY is combinational from registered state.
  - PRDATA = register[idx] when PREADY & !PWRITE & !misaligned; otherwise 0.
  - For idx in the RO range, PRDATA returns the corresponding ro_in slice.
  - PSLVERR = PREADY & misaligned.
- Timing: setup cycle + (WAIT_STATES+1) access cycles; PREADY is high on exactly the last access cycle.
- Write commit:
  - Occurs at the clock edge where PSEL & PENABLE & PREADY & PWRITE & !misaligned & idx < REG_COUNT-RO_REGS.
  - register[idx] <= PWDATA.
  - wr_pulse[idx] = 1 for the following cycle only; all other wr_pulse bits are 0.
- Writes to RO registers: complete with PREADY = 1, PSLVERR = 0, and no state change.
- Misaligned accesses: no write and no pulse; PRDATA = 0.
- Back-to-back transfers (setup on the cycle right after DONE): must be accepted with no idle cycle.
- Reset asserted mid-transfer: immediate return to IDLE; registers cleared; the transfer is not completed.

Test Plan:
- Reset, then read 32'h8c000000 with WAIT_STATES = 0 -> PREADY = 1 in the first access cycle, PRDATA = 0, PSLVERR = 0.
- Write 32'hdeadbeef to 32'h8c000008 -> regs_out reg2 = 32'hdeadbeef, wr_pulse = 1 << 2 for exactly one cycle; read-back returns 32'hdeadbeef.
- WAIT_STATES = 3, write to 32'h8c000004 -> PREADY low for 3 access cycles and high on the 4th; write commits only on the 4th.
- Drive ro_in slice 0 = 32'h12345678, read 32'h8c0001b0 (idx 108 with defaults) -> PRDATA = 32'h12345678. Write 32'hffffffff to the same address -> PREADY = 1, PSLVERR = 0, and a following read still returns 32'h12345678.
- Access 32'h8c000006 -> PSLVERR = 1, no wr_pulse, register unchanged. Access 32'h8c000300 -> PREADY stays 0 and PRDATA = 0 throughout.
- WAIT_STATES = 3, start a write, drop PSEL after 1 wait cycle -> no write, FSM back in IDLE. Repeat the write with rst pulsed during the wait -> all regs_out = 0 and no PREADY.
